// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM stage and MEM/WB register.
// Holds the data-memory access FSM encoding and timing defaults.
package mem_wb_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FAULT  = 2'd2
    } mem_state_e;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake: request/ack tracking, wait counter and fault latch.
// Outputs are forced low while reset is held so a live request drops at once.
module mem_access_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_read,
    input  logic mem_write,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic dmem_we,
    output logic mem_stall,
    output logic ack_ok,
    output logic mem_fault
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    mem_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic       memop;
    logic       req;

    assign memop = mem_read | mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        ack_ok  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req = memop;
                if (memop) begin
                    if (dmem_ack) begin
                        ack_ok = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 8'd1;
                    end
                end
            end
            ACCESS: begin
                req = 1'b1;
                if (dmem_ack) begin
                    ack_ok  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == LIMIT) begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                req = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // Read+write together is illegal but still serviced as a write
        fault_d = fault_q
                | (req & mem_read & mem_write)
                | (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign dmem_req  = reset & req;
    assign dmem_we   = reset & req & mem_write;
    assign mem_stall = reset
                     & ((memop & ~ack_ok & (state_q != FAULT))
                     | (state_q == FAULT));
    assign mem_fault = fault_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: branch resolution, data-memory access and the MEM/WB register.
// A stalled edge inserts a bubble; data fields keep their last values.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EXMEM_Branch,
    input  logic        EXMEM_MemRead,
    input  logic        EXMEM_MemWrite,
    input  logic        EXMEM_MemtoReg,
    input  logic        EXMEM_RegWrite,
    input  logic        EXMEM_Jal,
    input  logic        EXMEM_Zero,
    input  logic [4:0]  EXMEM_RD,
    input  logic [63:0] EXMEM_Adder2Out,
    input  logic [63:0] EXMEM_Result,
    input  logic [63:0] EXMEM_WriteData,
    input  logic [63:0] EXMEM_adder_out1,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        mem_stall,
    output logic        PCSrc,
    output logic [63:0] branch_target,
    output logic        mem_fault,
    output logic        MEMWB_RegWrite,
    output logic        MEMWB_MemtoReg,
    output logic        MEMWB_Jal,
    output logic [4:0]  MEMWB_RD,
    output logic [63:0] MEMWB_ReadData,
    output logic [63:0] MEMWB_Result,
    output logic [63:0] MEMWB_LinkAddr
);

    logic ack_ok;

    mem_access_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .mem_read (EXMEM_MemRead),
        .mem_write(EXMEM_MemWrite),
        .dmem_ack (dmem_ack),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .mem_stall(mem_stall),
        .ack_ok   (ack_ok),
        .mem_fault(mem_fault)
    );

    assign dmem_addr     = EXMEM_Result;
    assign dmem_wdata    = EXMEM_WriteData;
    assign PCSrc         = (EXMEM_Branch & EXMEM_Zero) | EXMEM_Jal;
    assign branch_target = EXMEM_Adder2Out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MEMWB_RegWrite <= 1'b0;
            MEMWB_MemtoReg <= 1'b0;
            MEMWB_Jal      <= 1'b0;
            MEMWB_RD       <= 5'd0;
            MEMWB_ReadData <= 64'd0;
            MEMWB_Result   <= 64'd0;
            MEMWB_LinkAddr <= 64'd0;
        end else if (!mem_stall) begin
            MEMWB_RegWrite <= EXMEM_RegWrite;
            MEMWB_MemtoReg <= EXMEM_MemtoReg;
            MEMWB_Jal      <= EXMEM_Jal;
            MEMWB_RD       <= EXMEM_RD;
            MEMWB_Result   <= EXMEM_Result;
            MEMWB_LinkAddr <= EXMEM_adder_out1;
            if (EXMEM_MemRead & ack_ok) begin
                MEMWB_ReadData <= dmem_rdata;
            end
        end else begin
            MEMWB_RegWrite <= 1'b0;
            MEMWB_MemtoReg <= 1'b0;
            MEMWB_Jal      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected MEM/WB contents are queued
// when an op is driven and compared on the edge that captures it.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br = 0, mrd = 0, mwr = 0, m2r = 0, rw = 0, jl = 0, zr = 0;
    logic [4:0]  rd = 0;
    logic [63:0] a2 = 0, res = 0, wd = 0, lnk = 0;
    logic        dmem_req, dmem_we, dmem_ack = 0;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
    logic        mem_stall, PCSrc, mem_fault;
    logic [63:0] branch_target;
    logic        wb_rw, wb_m2r, wb_jal;
    logic [4:0]  wb_rd;
    logic [63:0] wb_rdat, wb_res, wb_link;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        jal;
        logic [4:0]  rd;
        logic [63:0] rdat;
        logic [63:0] res;
        logic [63:0] link;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] last_rd = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .EXMEM_Branch(br), .EXMEM_MemRead(mrd), .EXMEM_MemWrite(mwr),
        .EXMEM_MemtoReg(m2r), .EXMEM_RegWrite(rw), .EXMEM_Jal(jl),
        .EXMEM_Zero(zr), .EXMEM_RD(rd),
        .EXMEM_Adder2Out(a2), .EXMEM_Result(res),
        .EXMEM_WriteData(wd), .EXMEM_adder_out1(lnk),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .PCSrc(PCSrc),
        .branch_target(branch_target), .mem_fault(mem_fault),
        .MEMWB_RegWrite(wb_rw), .MEMWB_MemtoReg(wb_m2r),
        .MEMWB_Jal(wb_jal), .MEMWB_RD(wb_rd),
        .MEMWB_ReadData(wb_rdat), .MEMWB_Result(wb_res),
        .MEMWB_LinkAddr(wb_link)
    );

    task automatic clear_inputs();
        br = 0; mrd = 0; mwr = 0; m2r = 0; rw = 0; jl = 0; zr = 0;
        rd = 0; a2 = 0; res = 0; wd = 0; lnk = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Leaves time at posedge+1 with reset released
    task automatic test_reset();
        exp_t got;
        reset = 1'b0;
        clear_inputs();
        sb.delete();
        last_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        got = {wb_rw, wb_m2r, wb_jal, wb_rd, wb_rdat, wb_res, wb_link};
        n_chk++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_memwb got=%h want=0", got);
        end
        n_chk++;
        if ({dmem_req, mem_stall, mem_fault} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=000",
                     {dmem_req, mem_stall, mem_fault});
        end
        reset = 1'b1;
    endtask

    // Entered at posedge+1; ack_at is the cycle index carrying dmem_ack
    task automatic run_op(
        input logic        i_br, i_zr, i_rd, i_wr, i_m2r, i_rw, i_jl,
        input logic [4:0]  i_dst,
        input logic [63:0] i_a2, i_res, i_wd, i_lnk, i_rdata,
        input int          ack_at,
        input string       nm
    );
        exp_t e, got;
        logic memop, done, exp_stall;
        int   stalls;
        br = i_br; zr = i_zr; mrd = i_rd; mwr = i_wr; m2r = i_m2r;
        rw = i_rw; jl = i_jl; rd = i_dst; a2 = i_a2; res = i_res;
        wd = i_wd; lnk = i_lnk; dmem_rdata = i_rdata;
        memop = i_rd | i_wr;
        e.rw = i_rw; e.m2r = i_m2r; e.jal = i_jl; e.rd = i_dst;
        e.rdat = i_rd ? i_rdata : last_rd;
        e.res = i_res; e.link = i_lnk;
        last_rd = e.rdat;
        sb.push_back(e);
        done = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            dmem_ack = (cyc == ack_at);
            #2;
            exp_stall = memop && (cyc != ack_at);
            if (cyc == 0) begin
                n_chk++;
                if ({PCSrc, branch_target, dmem_addr, dmem_wdata} !==
                    {(i_br & i_zr) | i_jl, i_a2, i_res, i_wd}) begin
                    n_fail++;
                    $display("FAIL %s comb got=%b %h %h %h want=%b %h %h %h",
                             nm, PCSrc, branch_target, dmem_addr, dmem_wdata,
                             (i_br & i_zr) | i_jl, i_a2, i_res, i_wd);
                end
            end
            n_chk++;
            if ({dmem_req, dmem_we, mem_stall} !==
                {memop, memop & i_wr, exp_stall}) begin
                n_fail++;
                $display("FAIL %s cyc%0d req/we/stall got=%b want=%b",
                         nm, cyc, {dmem_req, dmem_we, mem_stall},
                         {memop, memop & i_wr, exp_stall});
            end
            @(posedge clk);
            #1;
            dmem_ack = 0;
            if (exp_stall) begin
                stalls++;
                n_chk++;
                if ({wb_rw, wb_m2r, wb_jal} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL %s bubble got=%b want=000",
                             nm, {wb_rw, wb_m2r, wb_jal});
                end
            end else begin
                e = sb.pop_front();
                got = {wb_rw, wb_m2r, wb_jal, wb_rd, wb_rdat, wb_res, wb_link};
                n_chk++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s memwb got=%h want=%h", nm, got, e);
                end
                done = 1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s no capture within 40 cycles", nm);
        end
        clear_inputs();
    endtask

    task automatic test_load();
        run_op(0, 0, 1, 0, 1, 1, 0, 5'd7, 64'h0, 64'h100, 64'h0, 64'h0,
               64'hDEADBEEF, 2, "load");
        n_chk++;
        if (wb_rdat !== 64'hDEADBEEF || wb_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL load_data got=%h/%0d want=deadbeef/7",
                     wb_rdat, wb_rd);
        end
    endtask

    task automatic test_store();
        run_op(0, 0, 0, 1, 0, 0, 0, 5'd3, 64'h0, 64'h8, 64'h55, 64'h0,
               64'h0, 0, "store");
        #2;
        n_chk++;
        if ({dmem_we, dmem_req, wb_rw} !== 3'b000) begin
            n_fail++;
            $display("FAIL store_after got=%b want=000",
                     {dmem_we, dmem_req, wb_rw});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_branch_jal();
        run_op(1, 1, 0, 0, 0, 0, 0, 5'd0, 64'h40, 64'h0, 64'h0, 64'h0,
               64'h0, -1, "branch");
        run_op(1, 0, 0, 0, 0, 0, 0, 5'd0, 64'h80, 64'h4, 64'h0, 64'h0,
               64'h0, -1, "not_taken");
        run_op(0, 0, 0, 0, 0, 1, 1, 5'd1, 64'h0, 64'h0, 64'h0, 64'h24,
               64'h0, -1, "jal");
        n_chk++;
        if (wb_link !== 64'h24 || wb_jal !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_link got=%h/%b want=24/1", wb_link, wb_jal);
        end
    endtask

    task automatic test_back_to_back();
        run_op(0, 0, 1, 0, 1, 1, 0, 5'd10, 64'h0, 64'h200, 64'h0, 64'h0,
               64'h1111, 1, "b2b_a");
        run_op(0, 0, 1, 0, 1, 1, 0, 5'd11, 64'h0, 64'h208, 64'h0, 64'h0,
               64'h2222, 0, "b2b_b");
        run_op(0, 0, 0, 1, 0, 0, 0, 5'd12, 64'h0, 64'h210, 64'hAB, 64'h0,
               64'h0, 3, "b2b_st");
        // stray ack with no request must not disturb anything
        run_op(0, 0, 0, 0, 0, 1, 0, 5'd13, 64'h0, 64'h5, 64'h0, 64'h0,
               64'h9999, 0, "stray_ack");
    endtask

    task automatic test_reset_mid_access();
        exp_t got;
        mrd = 1; rw = 1; m2r = 1; rd = 5'd9; res = 64'h300;
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset req/stall got=%b%b want=11",
                     dmem_req, mem_stall);
        end
        reset = 1'b0;
        #1;
        got = {wb_rw, wb_m2r, wb_jal, wb_rd, wb_rdat, wb_res, wb_link};
        n_chk++;
        if ({dmem_req, mem_stall, mem_fault, got} !== '0) begin
            n_fail++;
            $display("FAIL async_reset req=%b stall=%b fault=%b wb=%h",
                     dmem_req, mem_stall, mem_fault, got);
        end
        clear_inputs();
        sb.delete();
        last_rd = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_op(0, 0, 1, 0, 1, 1, 0, 5'd4, 64'h0, 64'h308, 64'h0, 64'h0,
               64'hCAFE, 1, "post_reset_load");
    endtask

    task automatic test_illegal();
        run_op(0, 0, 1, 1, 0, 0, 0, 5'd2, 64'h0, 64'h400, 64'h77, 64'h0,
               last_rd, 1, "illegal");
        n_chk++;
        if (mem_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_fault got=%b want=1", mem_fault);
        end
    endtask

    task automatic test_timeout();
        int reqs;
        int stuck;
        logic fell;
        test_reset();
        mrd = 1; rw = 1; rd = 5'd6; res = 64'h500;
        reqs = 0;
        fell = 0;
        for (int c = 0; c < 300 && !fell; c++) begin
            #2;
            if (dmem_req) reqs++;
            else fell = 1;
            if (!fell) begin
                @(posedge clk);
                #1;
            end
        end
        n_chk++;
        if (!fell || reqs != 16) begin
            n_fail++;
            $display("FAIL timeout_len got=%0d fell=%b want=16", reqs, fell);
        end
        n_chk++;
        if ({mem_fault, mem_stall, dmem_req} !== 3'b110) begin
            n_fail++;
            $display("FAIL timeout_state got=%b want=110",
                     {mem_fault, mem_stall, dmem_req});
        end
        clear_inputs();
        dmem_ack = 1;
        stuck = 0;
        repeat (5) begin
            @(posedge clk);
            #2;
            if (mem_stall && !dmem_req && !wb_rw) stuck++;
        end
        dmem_ack = 0;
        n_chk++;
        if (stuck != 5) begin
            n_fail++;
            $display("FAIL fault_sticky got=%0d want=5", stuck);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_branch_jal();
        test_back_to_back();
        test_reset_mid_access();
        test_illegal();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter TIMEOUT, default 16; memory-ack wait limit in cycles, legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 EXMEM_Branch, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_RegWrite, EXMEM_Jal, EXMEM_Zero  input  1 each  control bits from the EX/MEM register.
REQ-005 EXMEM_RD  input  5  destination register.
REQ-006 EXMEM_Adder2Out, EXMEM_Result, EXMEM_WriteData, EXMEM_adder_out1  input  64 each  branch target, ALU result/address, store data, link address (PC+4).
REQ-007 dmem_req  output  1  data-memory request, held until ack.
REQ-008 dmem_we  output  1  1 = write, 0 = read.
REQ-009 dmem_addr, dmem_wdata  output  64 each  driven from EXMEM_Result and EXMEM_WriteData.
REQ-010 dmem_ack  input  1  one-cycle completion strobe; dmem_rdata valid in the same cycle.
REQ-011 dmem_rdata  input  64  read data.
REQ-012 mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-013 PCSrc  output  1  taken-branch/jump select; branch_target  output  64  = EXMEM_Adder2Out.
REQ-014 mem_fault  output  1  sticky timeout or illegal-op flag.
REQ-015 MEMWB_RegWrite, MEMWB_MemtoReg, MEMWB_Jal  output  1 each; MEMWB_RD  output  5; MEMWB_ReadData, MEMWB_Result, MEMWB_LinkAddr  output  64 each  MEM/WB register.

Function
REQ-016 memop = EXMEM_MemRead | EXMEM_MemWrite; PCSrc = (EXMEM_Branch & EXMEM_Zero) | EXMEM_Jal, combinational.
REQ-017 FSM states: IDLE, ACCESS, FAULT.
REQ-018 IDLE: dmem_req = memop, combinational; ack in the same cycle completes with zero stall; memop without ack goes to ACCESS with wait counter = 1.
REQ-019 ACCESS: dmem_req = 1; addr, wdata and we stay stable (inputs are frozen by mem_stall); counter increments each cycle; ack returns to IDLE.
REQ-020 In ACCESS, if the counter reaches TIMEOUT without ack, the FSM goes to FAULT, sets mem_fault, and deasserts dmem_req.
REQ-021 FAULT: mem_stall = 1 and dmem_req = 0 permanently; only reset exits.
REQ-022 mem_stall = (memop & ~dmem_ack & state != FAULT) | (state == FAULT).
REQ-023 On any edge with mem_stall = 0, MEM/WB loads from EX/MEM; MEMWB_ReadData loads dmem_rdata when MemRead & ack, else holds.
REQ-024 On an edge with mem_stall = 1, MEM/WB loads a bubble: RegWrite = 0, Jal = 0, MemtoReg = 0; data fields hold.
REQ-025 MemRead & MemWrite both set: treated as a write (dmem_we = 1) and mem_fault set; the access still completes.
REQ-026 dmem_ack outside an outstanding request is ignored.
REQ-027 Back-to-back memops: each takes its own request; the second request is not raised before the first ack's edge has been captured.

Reset
REQ-028 reset low sets state IDLE, counter 0, mem_fault 0, and every MEMWB_* output 0, asynchronously; dmem_req falls immediately, including mid-ACCESS.
REQ-029 Release is synchronous to clk; the first request may issue in the cycle after release.

Structure
REQ-030 FSM state encoding and the default TIMEOUT value go in the shared pipeline package.
REQ-031 One sub-module, mem_access_fsm, holds the FSM, counter and handshake; the MEM/WB register stays in the top.

Verification
REQ-032 Load, ack on 3rd cycle: Result = 0x100, rdata = 0xDEADBEEF -> mem_stall high for 2 cycles, 2 bubbles, then MEMWB_ReadData = 0xDEADBEEF, MEMWB_RD preserved.
REQ-033 Store with zero-wait ack: WriteData = 0x55 at addr 0x8 -> dmem_we = 1 for exactly one cycle, no stall, MEMWB_RegWrite = 0.
REQ-034 Branch = 1, Zero = 1, Adder2Out = 0x40 -> PCSrc = 1 and branch_target = 0x40 in the same cycle; Jal = 1, adder_out1 = 0x24 -> MEMWB_LinkAddr = 0x24.
REQ-035 Load with no ack, TIMEOUT = 16 -> FAULT after 16 cycles, mem_fault = 1, dmem_req = 0, mem_stall stuck at 1.
REQ-036 reset pulsed low mid-ACCESS -> dmem_req = 0 and all outputs 0 before the next edge; a fresh load after release completes normally.
REQ-037 MemRead = MemWrite = 1 -> write performed and mem_fault = 1.
